// File: rtl/mux_scan_ctrl.sv
// Four-channel scan controller for a 4:1 mux. It steps the selects through channels 0..3,
// dwells DWELL cycles on each, captures y, and publishes the four bits with a done pulse.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [3:0] sample,
  output logic       done
);

  localparam int unsigned CW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    shd_q, shd_d;
  logic [3:0]    sample_q, sample_d;
  logic          done_q, done_d;

  // NOTE: every target gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shd_d    = shd_q;
    sample_d = sample_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          ch_d    = 2'd0;
          cnt_d   = '0;
          shd_d   = 4'b0000;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          shd_d[ch_q]  = y;
          ch_d         = ch_q + 2'd1;
          // Channel 3 capture ends the scan; the ch wrap puts the selects back on channel 0.
          if (ch_q == 2'd3) begin
            sample_d = {y, shd_q[2:0]};
            done_d   = 1'b1;
            shd_d    = 4'b0000;
            if (!cont) state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= '0;
      shd_q    <= 4'b0000;
      sample_q <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shd_q    <= shd_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign s1     = ch_q[0];
  assign s0     = ch_q[1];
  assign busy   = (state_q == SCAN);
  assign sample = sample_q;
  assign done   = done_q;

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Four-channel scan controller that drives the select lines of the 4:1 mux (`mux4x1`) and captures its output `y` into a 4-bit sample word. On `start` it steps the mux through channels 0 to 3, holding each channel for `DWELL` cycles before sampling. It then presents all four captured bits in parallel with a one-cycle `done` pulse. It sits directly upstream (select generation) and downstream (sampling of `y`) of the mux in the channel-read path.

## Interface
- `DWELL`, default 4: cycles each channel is held; legal range 2..256. The mux output settles for `DWELL-1` cycles before capture.
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: begin a scan; sampled only in IDLE.
- `cont`  input  1: continuous mode; sampled at scan end.
- `y`  input  1: mux output, combinational from current selects.
- `s1`  output  1: mux select, channel index bit 0.
- `s0`  output  1: mux select, channel index bit 1.
- `busy`  output  1: high while in SCAN.
- `sample`  output  4: last completed scan; `sample[k]` is the value of channel k (A_k).
- `done`  output  1: one-cycle pulse when `sample` updates.

## Operation
- Channel mapping, fixed:
  - channel k selects A_k via `s1 = k[0]` and `s0 = k[1]`.
  - Sequence of (s0,s1): (0,0), (0,1), (1,0), (1,1).
- Registers:
  - 2-bit channel index `ch`.
  - Dwell counter `cnt`, width `$clog2(DWELL)`.
  - 4-bit shadow `shd`.
  - `sample`, `done`, and state.
- States:
  - **IDLE**
    - `busy=0`; selects hold last value (0 after reset).
    - If `start`=1: go to SCAN with `ch=0`, `cnt=0`, `shd=0`.
  - **SCAN**
    - `busy=1`; each cycle `cnt++`.
    - When `cnt==DWELL-1`: `shd[ch] <= y`, `cnt <= 0`, `ch <= ch+1` (wraps 3 to 0).
- Scan end, i.e. the capture of ch 3:
  - `sample <= {y, shd[2:0]}` and `done <= 1` for exactly one cycle.
  - If `cont`=1: stay in SCAN with `ch=0` and `cnt=0`, with no idle gap. `shd` is cleared.
  - If `cont`=0: return to IDLE. Selects return to (0,0) through the `ch` wrap.
- `start` while in SCAN is ignored; it does not restart the scan.
- `cont` is only examined at scan end.
- `y` is sampled only at capture edges; `y` between captures is don't-care.
- Reset values, applied at any time including mid-scan:
  - state IDLE, `ch=0`, `cnt=0`, `shd=0`.
  - `sample=4'b0000`, `done=0`, `busy=0`, `s1=0`, `s0=0`.
  - A partial scan is discarded; `sample` is not updated.
- `rst` has priority over `start` in the same cycle.

## Timing
- Edge E0 samples `start=1`. From E0 onward: `busy=1`, selects = channel 0.
- Channel k is captured at edge E0+(k+1)·DWELL. Selects change to channel k+1 at that same edge.
- `done` and the new `sample` are visible after edge E0+4·DWELL, for one cycle.
  - `busy` falls at the same edge if `cont=0`.
  - Latency from start to done is 4·DWELL cycles (16 at default).
- Continuous mode: `done` repeats every 4·DWELL cycles.
- Earliest restart after a non-continuous scan: `start` sampled at edge E0+4·DWELL+1, i.e. the first IDLE cycle.
- Outputs are all registered; no combinational path from `start`, `cont` or `y` to any output.

## Test plan
- Reset:
  - Assert `rst` 2 cycles with `start=1`.
  - Require `busy=0`, `done=0`, `sample=0000`, `s0=s1=0`, and state to remain IDLE.
- Single scan, DWELL=4, bench instantiates `mux4x1` fed by the selects:
  - Stimulus: A0=1, A1=0, A2=1, A3=1, `start` pulsed at E0.
  - Require (s0,s1) = 00, 01, 10, 11, each for 4 cycles.
  - Require `done` for one cycle after E0+16, with `sample=4'b1101`, and `busy` low at the same edge.
- Ignored start:
  - Re-pulse `start` at E0+5 during the scan.
  - Require an unchanged sequence, `done` only at E0+16, and no second scan.
- Continuous mode:
  - Stimulus: `cont=1`, A=0101 for scan 1, then switched to A=1010 at E0+16.
  - Require `done` at E0+16 with `sample=0101`, and at E0+32 with `sample=1010`.
  - Require `busy` to stay high throughout and selects to return to 00 at E0+16.
- Reset mid-scan:
  - Assert `rst` at E0+9, with ch 2 active and `sample=0101` held from an earlier scan.
  - Require IDLE, selects 00, `sample=0000`, and no `done`.
  - Then `start`: a full scan completes normally.
- DWELL=2:
  - Require each channel held 2 cycles, `done` at E0+8, and correct `sample`.
